// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, with byte-lane merge
// for sub-word stores, sign/zero extension for sub-word loads and a fixed response latency.
module dmem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic               we_q;
    logic               uns_q;
    logic               err_q;
    logic [1:0]         size_q;
    logic [IDX_W+1:0]   addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        mem [DEPTH];

    logic [IDX_W-1:0]   idx;
    logic [4:0]         byte_sh;
    logic [4:0]         half_sh;
    logic [31:0]        cur_word;
    logic [7:0]         byte_lane;
    logic [15:0]        half_lane;
    logic [31:0]        load_data;
    logic [31:0]        store_word;
    logic               req_err;
    logic               commit;

    // Address bits above the word index alias onto the same storage.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:IDX_W+2];

    assign req_ready = (state_q == StIdle);
    assign commit    = (state_q == StBusy) && (cnt_q == 4'd0);

    assign idx       = addr_q[IDX_W+1:2];
    assign byte_sh   = {addr_q[1:0], 3'b000};
    assign half_sh   = {addr_q[1], 4'b0000};
    assign cur_word  = mem[idx];
    assign byte_lane = cur_word[byte_sh +: 8];
    assign half_lane = cur_word[half_sh +: 16];

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    always_comb begin
        load_data = cur_word;
        case (size_q)
            2'b00:   load_data = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
            2'b01:   load_data = {{16{half_lane[15] & ~uns_q}}, half_lane};
            default: load_data = cur_word;
        endcase
    end

    always_comb begin
        store_word = cur_word;
        case (size_q)
            2'b00:   store_word[byte_sh +: 8]  = wdata_q[7:0];
            2'b01:   store_word[half_sh +: 16] = wdata_q[15:0];
            2'b10:   store_word                = wdata_q;
            default: store_word                = cur_word;
        endcase
    end

    // Storage is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && we_q && !err_q) begin
            mem[idx] <= store_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        err_q   <= req_err;
                        size_q  <= req_size;
                        addr_q  <= req_addr[IDX_W+1:0];
                        wdata_q <= req_wdata;
                        cnt_q   <= CNT_INIT;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        rsp_rdata <= (err_q || we_q) ? 32'h0 : load_data;
                        state_q   <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, handshake corner cases, latency variants
// and randomized traffic against a word-array reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid, req_ready, req_we, req_unsigned;
    logic [2:0]  rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  req_size [3];
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata [3];
    logic [31:0] rsp_rdata [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance 0: LATENCY=2 (main), 1: LATENCY=1, 2: LATENCY=15.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH   (64),
            .LATENCY (g == 0 ? 2 : (g == 1 ? 1 : 15))
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_we       (req_we[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
    endfunction

    // Reference model: plain word array plus arithmetic on byte offsets.
    logic [31:0] model_mem [64];

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
               (size == 2'b10 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [31:0] addr);
        logic [31:0] v;
        if (size == 2'b10) return word;
        if (size == 2'b00) begin
            v = (word >> (8 * (addr % 4))) & 32'd255;
            if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else begin
            v = (word >> (8 * (addr % 4))) & 32'd65535;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] size,
                                                input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] mask;
        int unsigned sh;
        if (size == 2'b10) return wdata;
        mask = (size == 2'b00) ? 32'hFF : 32'hFFFF;
        sh   = 8 * (addr % 4);
        return (word & ~(mask << sh)) | ((wdata & mask) << sh);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input int d, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        check("req_ready idle", 64'(req_ready[d]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        // Garble the request fields: they must be ignored after acceptance.
        req_valid[d]    = 1'b0;
        req_we[d]       = 1'($urandom);
        req_size[d]     = 2'($urandom);
        req_unsigned[d] = 1'($urandom);
        req_addr[d]     = $urandom;
        req_wdata[d]    = $urandom;
        check("req_ready busy", 64'(req_ready[d]), 64'd0);
    endtask

    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic handshake(input int d);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("post-handshake {valid,err,ready,rdata}",
              64'({rsp_valid[d], rsp_err[d], req_ready[d], rsp_rdata[d]}),
              64'({1'b0, 1'b0, 1'b1, 32'h0}));
    endtask

    task automatic xact(input int d, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int lat;
        send(d, we, size, uns, addr, wdata);
        wait_valid(d, lat);
        check({tag, " latency"}, 64'(lat), 64'(lat_of(d)));
        check({tag, " rdata"}, 64'(rsp_rdata[d]), 64'(exp_rdata));
        check({tag, " err"}, 64'(rsp_err[d]), 64'(exp_err));
        handshake(d);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int lat;
        int nv;
        logic [31:0] addr, wdata, exp;
        logic we, uns, err;
        logic [1:0] size;
        int idx;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        32'h000000DE, 1'b0};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'h0000DEAD, 1'b0};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h11,  32'h12345677, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEAD77EF, 1'b0};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h12,  32'h0000ABCD, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hABCD77EF, 1'b0};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h13,  32'h00005555, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hABCD77EF, 1'b0};
        vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 32'h11,  32'h0,        32'h00000077, 1'b0};
        vecs[15] = '{1'b0, 2'b01, 1'b1, 32'h10,  32'h0,        32'h000077EF, 1'b0};
        vecs[16] = '{1'b0, 2'b10, 1'b1, 32'h110, 32'h0,        32'hABCD77EF, 1'b0};
        vecs[17] = '{1'b1, 2'b10, 1'b0, 32'h20,  32'hCAFEF00D, 32'h0,        1'b0};
        vecs[18] = '{1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'hFFFFCAFE, 1'b0};

        req_valid = '0; req_we = '0; req_unsigned = '0; rsp_ready = '0;
        for (int d = 0; d < 3; d++) begin
            req_size[d]  = 2'b00;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset state d%0d {ready,valid,err,rdata}", d),
                  64'({req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]}),
                  64'({1'b1, 1'b0, 1'b0, 32'h0}));
        end

        // Directed vector table on the LATENCY=2 instance.
        for (int i = 0; i < 19; i++) begin
            xact(0, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
            if (vecs[i].we && !model_err(vecs[i].size, vecs[i].addr)) begin
                idx = int'((vecs[i].addr >> 2) % 64);
                model_mem[idx] = model_store(model_mem[idx], vecs[i].size, vecs[i].addr,
                                             vecs[i].wdata);
            end
        end

        // Backpressure: response held 5 cycles while a new request waits.
        send(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        wait_valid(0, lat);
        check("bp latency", 64'(lat), 64'd2);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'b01;
        req_unsigned[0] = 1'b1; req_addr[0] = 32'h12; req_wdata[0] = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp hold%0d {valid,ready,err,rdata}", c),
                  64'({rsp_valid[0], req_ready[0], rsp_err[0], rsp_rdata[0]}),
                  64'({1'b1, 1'b0, 1'b0, 32'hABCD77EF}));
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        check("bp after handshake {valid,ready}", 64'({rsp_valid[0], req_ready[0]}),
              64'({1'b0, 1'b1}));
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("bp held request accepted", 64'(req_ready[0]), 64'd0);
        wait_valid(0, lat);
        check("bp second latency", 64'(lat), 64'd2);
        check("bp second rdata", 64'(rsp_rdata[0]), 64'h0000ABCD);
        handshake(0);

        // Reset on the commit edge of a store abandons it.
        send(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid-reset {ready,valid}", 64'({req_ready[0], rsp_valid[0]}), 64'({1'b1, 1'b0}));
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid[0] === 1'b1) nv++;
        end
        check("mid-reset no response", 64'(nv), 64'd0);
        xact(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "mid-reset lw");

        // Latency variants.
        xact(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "L1 sw");
        xact(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "L1 lw");
        xact(2, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "L15 sw");
        xact(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "L15 lw");

        // Randomized traffic over 16 words with aliased upper address bits.
        for (int i = 0; i < 16; i++) begin
            wdata = $urandom;
            addr  = ($urandom & 32'hFFFFFF00) | 32'(i << 2);
            xact(0, 1'b1, 2'b10, 1'b0, addr, wdata, 32'h0, 1'b0, $sformatf("fill%0d", i));
            model_mem[i] = wdata;
        end
        for (int i = 0; i < 150; i++) begin
            we    = 1'($urandom);
            size  = 2'($urandom);
            uns   = 1'($urandom);
            addr  = ($urandom & 32'hFFFFFF00) | ($urandom % 64);
            wdata = $urandom;
            idx   = int'((addr >> 2) % 64);
            err   = model_err(size, addr);
            exp   = (we || err) ? 32'h0 : model_load(model_mem[idx], size, uns, addr);
            xact(0, we, size, uns, addr, wdata, exp, err, $sformatf("rnd%0d", i));
            if (we && !err) model_mem[idx] = model_store(model_mem[idx], size, addr, wdata);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
